gost_gamma_ctrl: RTL and testbench

- Counter-mode ("gamma") sequencer for GOST 28147-89.
- Acts as the initiator on the cipher core's load/done/pdata/cdata interface: encrypts the IV once, then steps the N3/N4 counters and requests one keystream block per data block.
- Each keystream block is XORed with streamed 64-bit data; encrypt and decrypt are the same operation.
- Sits between a valid/ready data source and sink, with the cipher core (key driven externally) beside it.

---
 rtl/gost_pkg.sv | 28 ++
 rtl/gost_gamma_counter.sv | 48 ++++
 rtl/gost_gamma_ctrl.sv | 130 +++++++++++++
 tb/tb_gost_gamma_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gost_pkg.sv
// Shared constants, FSM state codes and modular arithmetic for the GOST 28147-89
// counter-mode ("gamma") sequencer.
//   C1 / C2            : N4 / N3 step increments
//   St*                : sequencer state codes
//   add_mod_2p32m1()   : addition mod 2^32-1 with end-around carry
package gost_pkg;

    localparam logic [31:0] C1 = 32'h01010104;
    localparam logic [31:0] C2 = 32'h01010101;

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StInitReq   = 3'd1;
    localparam logic [2:0] StInitWait  = 3'd2;
    localparam logic [2:0] StStep      = 3'd3;
    localparam logic [2:0] StGenReq    = 3'd4;
    localparam logic [2:0] StGenWait   = 3'd5;
    localparam logic [2:0] StHaveGamma = 3'd6;
    localparam logic [2:0] StDrain     = 3'd7;

    // End-around carry: a carry out of bit 31 is folded back into bit 0.
    // 32'hFFFFFFFF is a legal result and is never reduced to 0.
    function automatic logic [31:0] add_mod_2p32m1(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? (sum[31:0] + 32'd1) : sum[31:0];
    endfunction

endpackage

// File: rtl/gost_gamma_counter.sv
// N3/N4 counter pair for GOST counter mode.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load N3 <= cdata_i[31:0], N4 <= cdata_i[63:32]
//   cdata_i       : encrypted synchronisation message from the core
//   step_i        : advance N3 by C2 (mod 2^32) and N4 by C1 (mod 2^32-1)
//   next_o        : {N4_next, N3_next}, the values the next step will store
module gost_gamma_counter
    import gost_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [63:0] cdata_i,
    input  logic        step_i,
    output logic [63:0] next_o
);

    logic [31:0] n3_q, n3_d;
    logic [31:0] n4_q, n4_d;
    logic [31:0] n3_next, n4_next;

    assign n3_next = n3_q + C2;
    assign n4_next = add_mod_2p32m1(n4_q, C1);
    assign next_o  = {n4_next, n3_next};

    always_comb begin
        n3_d = n3_q;
        n4_d = n4_q;
        if (load_i) begin
            n3_d = cdata_i[31:0];
            n4_d = cdata_i[63:32];
        end else if (step_i) begin
            n3_d = n3_next;
            n4_d = n4_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n3_q <= 32'd0;
            n4_q <= 32'd0;
        end else begin
            n3_q <= n3_d;
            n4_q <= n4_d;
        end
    end

endmodule

// File: rtl/gost_gamma_ctrl.sv
// GOST 28147-89 counter-mode sequencer. Encrypts the IV once through the cipher
// core, then per data block steps N3/N4, requests a keystream block and XORs it
// with the streamed data (encrypt and decrypt are identical).
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   start_i, iv_i, busy_o         : message start with synchronisation message
//   in_valid_i/in_ready_o/in_data_i/in_last_i     : data source handshake
//   out_valid_o/out_ready_i/out_data_o/out_last_o : data sink handshake
//   core_load_o/core_mode_o/core_pdata_o/core_done_i/core_cdata_i : cipher core
module gost_gamma_ctrl
    import gost_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [63:0] iv_i,
    output logic        busy_o,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [63:0] in_data_i,
    input  logic        in_last_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_data_o,
    output logic        out_last_o,
    output logic        core_load_o,
    output logic        core_mode_o,
    output logic [63:0] core_pdata_o,
    input  logic        core_done_i,
    input  logic [63:0] core_cdata_i
);

    logic [2:0]  state_q, state_d;
    logic [63:0] pdata_q, pdata_d;
    logic [63:0] gamma_q, gamma_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] ctr_next;
    logic        ctr_load, ctr_step;
    logic        accept;

    assign ctr_load = (state_q == StInitWait) && core_done_i;
    assign ctr_step = (state_q == StStep);

    gost_gamma_counter u_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (ctr_load),
        .cdata_i (core_cdata_i),
        .step_i  (ctr_step),
        .next_o  (ctr_next)
    );

    assign in_ready_o = (state_q == StHaveGamma) && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        pdata_d = pdata_q;
        gamma_d = gamma_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    pdata_d = iv_i;
                    state_d = StInitReq;
                end
            end
            StInitReq:  state_d = StInitWait;
            StInitWait: if (core_done_i) state_d = StStep;
            StStep: begin
                pdata_d = ctr_next;
                state_d = StGenReq;
            end
            StGenReq:   state_d = StGenWait;
            StGenWait: begin
                if (core_done_i) begin
                    gamma_d = core_cdata_i;
                    state_d = StHaveGamma;
                end
            end
            StHaveGamma: begin
                // Next gamma is generated while this output waits for the sink.
                if (accept) state_d = in_last_i ? StDrain : StStep;
            end
            StDrain:    if (!out_valid_q || out_ready_i) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Output register: a fresh block may replace one being handed off this cycle.
    always_comb begin
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = in_data_i ^ gamma_q;
            out_last_d  = in_last_i;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            pdata_q     <= 64'd0;
            gamma_q     <= 64'd0;
            out_data_q  <= 64'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pdata_q     <= pdata_d;
            gamma_q     <= gamma_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign core_load_o  = (state_q == StInitReq) || (state_q == StGenReq);
    assign core_mode_o  = 1'b0;
    assign core_pdata_o = pdata_q;
    assign out_data_o   = out_data_q;
    assign out_last_o   = out_last_q;
    assign out_valid_o  = out_valid_q;

endmodule

// File: tb/tb_gost_gamma_ctrl.sv
// Scoreboard bench for gost_gamma_ctrl with a toy cipher core
// (cdata = pdata ^ K, done 32 cycles after load).
module tb_gost_gamma_ctrl;

    localparam logic [63:0] K = 64'hA5A5A5A5_5A5A5A5A;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start = 1'b0;
    logic [63:0] iv = 64'd0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_last;
    logic        core_load;
    logic        core_mode;
    logic [63:0] core_pdata;
    logic        core_done = 1'b0;
    logic [63:0] core_cdata = 64'd0;

    int checks = 0;
    int failures = 0;
    int load_cnt = 0;
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
    bit core_abort = 1'b0;
    bit chk_busy = 1'b0;

    logic [63:0] exp_pdata_q[$];
    logic [64:0] exp_out_q[$];

    gost_gamma_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start),
        .iv_i         (iv),
        .busy_o       (busy),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .core_load_o  (core_load),
        .core_mode_o  (core_mode),
        .core_pdata_o (core_pdata),
        .core_done_i  (core_done),
        .core_cdata_i (core_cdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Reference arithmetic: N4 lives in Z/(2^32-1) with 0 represented as all-ones.
    function automatic logic [31:0] m_step_n4(input logic [31:0] x);
        logic [63:0] s, r;
        s = {32'd0, x} + 64'h0000_0000_0101_0104;
        r = s % 64'h0000_0000_FFFF_FFFF;
        if (r == 64'd0 && s != 64'd0) r = 64'h0000_0000_FFFF_FFFF;
        return r[31:0];
    endfunction

    function automatic logic [31:0] m_step_n3(input logic [31:0] x);
        return x + 32'h0101_0101;
    endfunction

    // Toy cipher core.
    initial begin
        logic [63:0] cap;
        forever begin
            @(negedge clk);
            if (rst_ni && core_load) begin
                cap = core_pdata;
                core_abort = 1'b0;
                repeat (31) @(posedge clk);
                #1;
                if (!core_abort) check("pdata_stable", core_pdata, cap);
                core_cdata = cap ^ K;
                core_done = 1'b1;
                @(posedge clk);
                #1 core_done = 1'b0;
            end
        end
    end

    always @(negedge rst_ni) core_abort = 1'b1;

    // Core request monitor.
    always @(negedge clk) begin
        if (rst_ni && core_load) begin
            load_cnt++;
            check("core_mode", {63'd0, core_mode}, 64'd0);
            if (exp_pdata_q.size() == 0) fail_now("unexpected_core_load");
            else check("core_pdata", core_pdata, exp_pdata_q.pop_front());
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        logic [64:0] e;
        if (chk_busy) begin
            chk_busy = 1'b0;
            check("busy_after_last", {63'd0, busy}, 64'd0);
        end
        if (rst_ni && out_valid && out_ready) begin
            if (exp_out_q.size() == 0) begin
                fail_now("unexpected_output");
            end else begin
                e = exp_out_q.pop_front();
                check("out_data", out_data, e[63:0]);
                check("out_last", {63'd0, out_last}, {63'd0, e[64]});
                if (e[64]) chk_busy = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic run_msg(input logic [63:0] msg_iv, input int n);
        logic [63:0] ns, g, d;
        logic [31:0] n3, n4;
        logic [64:0] blk[$];
        int base, guard;
        bit ok, last;
        ns = msg_iv ^ K;
        n4 = ns[63:32];
        n3 = ns[31:0];
        exp_pdata_q.push_back(msg_iv);
        for (int k = 0; k < n; k++) begin
            n3 = m_step_n3(n3);
            n4 = m_step_n4(n4);
            exp_pdata_q.push_back({n4, n3});
            g = {n4, n3} ^ K;
            d = {$urandom, $urandom};
            last = (k == n - 1);
            blk.push_back({last, d});
            exp_out_q.push_back({last, d ^ g});
        end
        base = load_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        iv = msg_iv;
        for (int k = 0; k < n; k++) begin
            if (k != 0) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            // The first block is offered together with start and must not be taken early.
            in_valid = 1'b1;
            in_data = blk[k][63:0];
            in_last = blk[k][64];
            guard = 0;
            ok = 1'b0;
            while (!ok && guard < 3000) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                start = 1'b0;
                guard++;
            end
            in_valid = 1'b0;
            if (!ok) fail_now("in_handshake_timeout");
        end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (busy && guard < 3000);
        check("busy_idle", {63'd0, busy}, 64'd0);
        check("load_count", 64'(load_cnt - base), 64'(n + 1));
        check("out_queue_empty", 64'(exp_out_q.size()), 64'd0);
    endtask

    initial begin
        int base, guard, viol;
        logic [63:0] snap;

        // Reset state.
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_core_load", {63'd0, core_load}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_core_pdata", core_pdata, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Three-block message from IV 0 (first GEN pdata A6A6A6A9_5B5B5B5B).
        run_msg(64'd0, 3);

        // End-around carry corners reached through the IV.
        run_msg({32'h5A5A5A5B, 32'h0}, 2);          // N4 FFFFFFFE -> 01010103
        run_msg({32'h5B5B5B5E, 32'h12345678}, 2);   // N4 FEFEFEFB -> FFFFFFFF
        run_msg({32'h5B5B5B5E, 32'hA5A5A5A5}, 1);   // N3 FFFFFFFF -> 01010100

        // Backpressure: first output held for 100 cycles.
        rdy_mode = 2;
        fork
            run_msg({$urandom, $urandom}, 3);
            begin
                guard = 0;
                do begin
                    @(negedge clk);
                    guard++;
                end while (!out_valid && guard < 500);
                snap = out_data;
                base = load_cnt;
                viol = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (out_data !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) viol++;
                end
                check("bp_hold_violations", 64'(viol), 64'd0);
                check("bp_core_loads", 64'(load_cnt - base), 64'd1);
                rdy_mode = 0;
            end
        join

        // start while busy is ignored.
        rdy_mode = 1;
        base = load_cnt;
        fork
            run_msg({$urandom, $urandom}, 3);
            begin
                guard = 0;
                while (load_cnt < base + 2 && guard < 500) begin
                    @(negedge clk);
                    guard++;
                end
                repeat (5) @(posedge clk);
                #1;
                start = 1'b1;
                iv = {$urandom, $urandom};
                @(posedge clk);
                #1 start = 1'b0;
            end
        join

        // Randomised messages with random sink readiness.
        for (int m = 0; m < 4; m++) run_msg({$urandom, $urandom}, $urandom_range(1, 5));

        // Reset during GEN_WAIT.
        rdy_mode = 0;
        base = load_cnt;
        iv = {$urandom, $urandom};
        exp_pdata_q.push_back(iv);
        exp_pdata_q.push_back({m_step_n4(iv[63:32] ^ K[63:32]), m_step_n3(iv[31:0] ^ K[31:0])});
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        guard = 0;
        while (load_cnt < base + 2 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("pre_reset_loads", 64'(load_cnt - base), 64'd2);
        repeat (10) @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_core_load", {63'd0, core_load}, 64'd0);
        check("abort_core_pdata", core_pdata, 64'd0);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        exp_pdata_q.delete();
        exp_out_q.delete();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("late_done_busy", {63'd0, busy}, 64'd0);
        check("late_done_loads", 64'(load_cnt - base), 64'd2);
        run_msg({$urandom, $urandom}, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
